// File: rtl/serial_rx_pkg.sv
// Shared types and limits for the serial-to-parallel receiver.
package serial_rx_pkg;

  typedef enum logic [0:0] {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } rx_state_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/parity_acc.sv
// Running XOR accumulator used for even-parity checking of received frames.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);

  logic acc_d, acc_q;

  // next accumulator value: clear dominates enable
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = acc_q ^ d;
    end else begin
      acc_d = acc_q;
    end
  end

  // accumulator register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// LSB-first serial receiver with a one-entry valid/ready output register.
// Optional even-parity bit per frame enabled by `SERIAL_RX_PARITY_CHECK_EN.
module serial_to_parallel_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             parallel_valid,
  input  logic             parallel_ready,
  output logic [WIDTH-1:0] parallel_data,
  output logic             parity_err,
  output logic             overflow
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // An out-of-range WIDTH elaborates a missing module and stops the build.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    illegal_width_parameter u_illegal_width ();
  end

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic [WIDTH-1:0] word_s;
  logic             complete_s;
  logic             pvalid_d, pvalid_q;
  logic [WIDTH-1:0] pdata_d, pdata_q;
  logic             overflow_d, overflow_q;

`ifdef SERIAL_RX_PARITY_CHECK_EN
  rx_state_e state_d, state_q;
  logic      acc_s, acc_clr_s, acc_en_s;
  logic      perr_s, perr_d, perr_q;

  parity_acc u_parity_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (acc_clr_s),
    .en   (acc_en_s),
    .d    (serial_data),
    .acc  (acc_s)
  );
`endif

  // frame assembly: bit counter, shift register and completion detect
  always_comb begin
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    word_s     = shreg_q;
    complete_s = 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
    state_d    = state_q;
    acc_clr_s  = 1'b0;
    acc_en_s   = 1'b0;
    perr_s     = 1'b0;
    if (serial_valid) begin
      case (state_q)
        S_DATA: begin
          shreg_d[cnt_q] = serial_data;
          acc_en_s       = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          // data bits are already complete in shreg_q; this bit only closes the frame
          complete_s = 1'b1;
          perr_s     = acc_s ^ serial_data;
          acc_clr_s  = 1'b1;
          cnt_d      = {CNT_W{1'b0}};
          state_d    = S_DATA;
        end
        default: begin
          cnt_d     = {CNT_W{1'b0}};
          acc_clr_s = 1'b1;
          state_d   = S_DATA;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
`else
    if (serial_valid) begin
      shreg_d[cnt_q] = serial_data;
      word_s         = shreg_d;
      if (cnt_q == CNT_LAST) begin
        complete_s = 1'b1;
        cnt_d      = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
`endif
  end

  // output register: load on completion when empty or popped, else flag overflow
  always_comb begin
    pvalid_d   = pvalid_q;
    pdata_d    = pdata_q;
    overflow_d = overflow_q;
`ifdef SERIAL_RX_PARITY_CHECK_EN
    perr_d     = perr_q;
`endif
    if (complete_s) begin
      if (!pvalid_q || parallel_ready) begin
        pvalid_d = 1'b1;
        pdata_d  = word_s;
`ifdef SERIAL_RX_PARITY_CHECK_EN
        perr_d   = perr_s;
`endif
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pvalid_q && parallel_ready) begin
      pvalid_d = 1'b0;
    end else begin
      pvalid_d = pvalid_q;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= {CNT_W{1'b0}};
      shreg_q    <= {WIDTH{1'b0}};
      pvalid_q   <= 1'b0;
      pdata_q    <= {WIDTH{1'b0}};
      overflow_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      state_q    <= S_DATA;
      perr_q     <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      pvalid_q   <= pvalid_d;
      pdata_q    <= pdata_d;
      overflow_q <= overflow_d;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      state_q    <= state_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign parallel_valid = pvalid_q;
  assign parallel_data  = pdata_q;
  assign overflow       = overflow_q;
`ifdef SERIAL_RX_PARITY_CHECK_EN
  assign parity_err     = perr_q;
`else
  assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed self-checking bench for serial_to_parallel_rx (WIDTH=8), either parity build.
module tb_serial_to_parallel_rx;

  localparam int WIDTH = 8;
`ifdef SERIAL_RX_PARITY_CHECK_EN
  localparam int FRAME_LEN = WIDTH + 1;
  localparam bit PAR_EN    = 1'b1;
`else
  localparam int FRAME_LEN = WIDTH;
  localparam bit PAR_EN    = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             serial_valid;
  logic             serial_data;
  logic             parallel_valid;
  logic             parallel_ready;
  logic [WIDTH-1:0] parallel_data;
  logic             parity_err;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  serial_to_parallel_rx #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_valid  (serial_valid),
    .serial_data   (serial_data),
    .parallel_valid(parallel_valid),
    .parallel_ready(parallel_ready),
    .parallel_data (parallel_data),
    .parity_err    (parity_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    serial_valid = 1'b1;
    serial_data  = b;
    @(posedge clk);
    #1;
    serial_valid = 1'b0;
    serial_data  = 1'b0;
  endtask

  // ready_last raises parallel_ready just before the frame's final bit
  task automatic send_frame(input logic [7:0] w, input logic pbit, input bit gaps, input bit ready_last);
    logic [8:0] bits;
    bits = {pbit, w};
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (gaps && (i % 2 == 1)) idle(1);
      if (ready_last && i == FRAME_LEN - 1) parallel_ready = 1'b1;
      send_bit(bits[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] ff_bits;
    rst_n          = 1'b0;
    serial_valid   = 1'b0;
    serial_data    = 1'b0;
    parallel_ready = 1'b0;
    idle(2);
    check_eq("rst_valid", 32'(parallel_valid), 32'h0);
    check_eq("rst_data", 32'(parallel_data), 32'h0);
    check_eq("rst_perr", 32'(parity_err), 32'h0);
    check_eq("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;

    // 0xA5 with correct parity, ready high: one-cycle valid
    parallel_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check_eq("a5_valid", 32'(parallel_valid), 32'h1);
    check_eq("a5_data", 32'(parallel_data), 32'hA5);
    check_eq("a5_perr", 32'(parity_err), 32'h0);
    idle(1);
    check_eq("a5_popped", 32'(parallel_valid), 32'h0);

    // 0xA5 with wrong parity bit, then 0x3C with correct parity
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_eq("a5bad_data", 32'(parallel_data), 32'hA5);
    check_eq("a5bad_perr", 32'(parity_err), 32'(PAR_EN));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("3c_data", 32'(parallel_data), 32'h3C);
    check_eq("3c_perr", 32'(parity_err), 32'h0);
    idle(1);

    // overflow: 0x01 held, 0x02 dropped
    parallel_ready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    check_eq("01_valid", 32'(parallel_valid), 32'h1);
    check_eq("01_ovf", 32'(overflow), 32'h0);
    send_frame(8'h02, 1'b1, 1'b0, 1'b0);
    check_eq("02_held_data", 32'(parallel_data), 32'h01);
    check_eq("02_ovf", 32'(overflow), 32'h1);
    parallel_ready = 1'b1;
    idle(1);
    check_eq("01_popped", 32'(parallel_valid), 32'h0);
    check_eq("ovf_sticky", 32'(overflow), 32'h1);

    // simultaneous pop and completion
    do_reset();
    check_eq("srst_ovf", 32'(overflow), 32'h0);
    parallel_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    check_eq("11_data", 32'(parallel_data), 32'h11);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check_eq("22_valid", 32'(parallel_valid), 32'h1);
    check_eq("22_data", 32'(parallel_data), 32'h22);
    check_eq("22_ovf", 32'(overflow), 32'h0);
    idle(1);
    check_eq("22_popped", 32'(parallel_valid), 32'h0);

    // reset mid-frame then a gapped frame 0x5A
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    do_reset();
    check_eq("midrst_data", 32'(parallel_data), 32'h0);
    check_eq("midrst_valid", 32'(parallel_valid), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_eq("5a_valid", 32'(parallel_valid), 32'h1);
    check_eq("5a_data", 32'(parallel_data), 32'h5A);
    check_eq("5a_perr", 32'(parity_err), 32'h0);
    idle(1);

    // 0xFF: nothing before the final bit, then back-to-back frame 0x0F
    ff_bits = {1'b0, 8'hFF};
    for (int i = 0; i < FRAME_LEN - 1; i++) send_bit(ff_bits[i]);
    check_eq("ff_early_valid", 32'(parallel_valid), 32'h0);
    send_bit(ff_bits[FRAME_LEN-1]);
    check_eq("ff_valid", 32'(parallel_valid), 32'h1);
    check_eq("ff_data", 32'(parallel_data), 32'hFF);
    check_eq("ff_perr", 32'(parity_err), 32'h0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    check_eq("0f_data", 32'(parallel_data), 32'h0F);
    check_eq("0f_ovf", 32'(overflow), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
SERIAL_TO_PARALLEL_RX -- requirements
Module: serial_to_parallel_rx

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of data bits per word (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 serial_valid  input  1  serial_data is a valid bit this cycle.
REQ-005 serial_data  input  1  serial bit; data bits arrive LSB first.
REQ-006 parallel_valid  output  1  parallel_data holds a completed word.
REQ-007 parallel_ready  input  1  downstream accepts the word when high together with parallel_valid.
REQ-008 parallel_data  output  WIDTH  assembled word.
REQ-009 parity_err  output  1  the held word failed its even-parity check; qualified by parallel_valid.
REQ-010 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-011 FSM states: S_DATA (collecting data bits) and S_PARITY (expecting the parity bit); the parity state exists only with the macro defined.
REQ-012 Bit counter: 0..WIDTH-1; increments only on cycles with serial_valid=1; idle cycles hold all state.
REQ-013 In S_DATA with serial_valid=1, the bit is shifted into bit position cnt and XORed into a running parity accumulator.
REQ-014 At cnt=WIDTH-1 with serial_valid=1, the word is complete (no macro) or the FSM moves to S_PARITY (macro).
REQ-015 In S_PARITY with serial_valid=1, the word is complete; the error is (accumulator XOR bit)=1; the FSM returns to S_DATA with cnt=0 and the accumulator cleared.
REQ-016 Completion latency: parallel_valid rises on the clock edge that samples the last bit of the frame (visible in the following cycle).
REQ-017 Output register is one entry: data and parity_err hold stable while parallel_valid=1 and parallel_ready=0.
REQ-018 Handshake: parallel_valid=1 and parallel_ready=1 at an edge drops parallel_valid, unless a new completion occurs at the same edge.
REQ-019 Simultaneous pop and completion: the new word loads and parallel_valid stays 1; no overflow.
REQ-020 Completion while parallel_valid=1 and parallel_ready=0: the new word is discarded, the held word is kept, and overflow is set.
REQ-021 overflow remains 1 until reset.
REQ-022 Reception never stalls: serial input is always accepted regardless of downstream state.

Reset
REQ-023 When rst_n=0 at an edge, the following take effect regardless of other inputs, including mid-frame or mid-handshake:
  - parallel_valid=0, parallel_data=0, parity_err=0, overflow=0;
  - FSM=S_DATA, cnt=0, accumulator=0;
  - any partial frame is discarded.
REQ-024 The first edge with rst_n=1 may sample bit 0 of a new frame.

Configuration
REQ-025 Macro SERIAL_RX_PARITY_CHECK_EN defined:
  - a frame is WIDTH data bits followed by one even-parity bit;
  - parity_err is computed as in REQ-015.
REQ-026 Macro SERIAL_RX_PARITY_CHECK_EN undefined:
  - a frame is WIDTH bits;
  - S_PARITY and the accumulator are absent;
  - parity_err is constant 0.

Structure
REQ-027 Package serial_rx_pkg holds:
  - the FSM state enum typedef (S_DATA, S_PARITY);
  - the constants for the minimum and maximum legal WIDTH.
REQ-028 Sub-module parity_acc (1-bit XOR accumulator with clear and enable, same clk/rst_n) implements the running parity; it is instantiated only under the macro.

Verification (WIDTH=8)
REQ-029 Bits of 0xA5 LSB first plus parity 0, parallel_ready=1 -> one cycle of parallel_valid with data 0xA5 and parity_err=0.
REQ-030 0xA5 with parity bit 1 -> data 0xA5 and parity_err=1; the next frame 0x3C with parity 0 -> parity_err=0.
REQ-031 Frame 0x01 with parallel_ready=0, then frame 0x02 -> data stays 0x01 and overflow=1. Raising ready pops 0x01; overflow stays 1.
REQ-032 Held word 0x11 with ready=1 at the same edge that completes 0x22 -> parallel_valid stays 1, data 0x22, overflow=0.
REQ-033 rst_n=0 after 4 bits of a frame, then a full frame 0x5A with gaps (serial_valid toggling) -> the output is 0x5A only, with no remnant of the earlier 4 bits.
REQ-034 Macro undefined: 8 bits of 0xFF -> valid after the 8th bit, parity_err=0; the 9th bit starts the next frame.
